// File: rtl/main_decoder_pkg.sv
// ============================================================================
// Module  : main_decoder_pkg
// Brief   : RV32I opcodes and control-field encodings shared by the decoders
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package main_decoder_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Field order matches the packed 13-bit control word, MSB first.
  typedef struct packed {
    logic       reg_write;
    logic [2:0] imm_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic       mem_write;
    logic [1:0] result_src;
    logic       branch;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

`default_nettype wire

// File: rtl/main_decoder_comb.sv
// ============================================================================
// Module  : main_decoder_comb
// Brief   : pure opcode -> control word lookup with illegal-opcode flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_decoder_comb
  import main_decoder_pkg::*;
(
  input  logic [6:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_I;
        ctrl.alu_src_b  = 1'b1;
        ctrl.result_src = RES_MEM;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl.imm_src   = IMM_S;
        ctrl.alu_src_b = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_RTYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_BRANCH: begin
        ctrl.imm_src = IMM_B;
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALUOP_SUB;
      end
      OP_ITYPE: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_I;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      OP_JAL: begin
        ctrl.reg_write  = 1'b1;
        ctrl.imm_src    = IMM_J;
        ctrl.result_src = RES_PC4;
        ctrl.jump       = 1'b1;
      end
      // lui computes 0 + U-immediate, so operand A is forced to zero.
      OP_LUI: begin
        ctrl.reg_write = 1'b1;
        ctrl.imm_src   = IMM_U;
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        ctrl    = CTRL_NOP;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/main_decoder.sv
// ============================================================================
// Module  : main_decoder
// Brief   : RV32I main control decoder with optional one-cycle output register
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module main_decoder
  import main_decoder_pkg::*;
#(
  parameter int REG_OUT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  output logic       reg_write,
  output logic [2:0] imm_src,
  output logic       alu_srcA,
  output logic       alu_srcB,
  output logic       mem_write,
  output logic [1:0] result_src,
  output logic       branch,
  output logic [1:0] alu_op,
  output logic       jump,
  output logic       illegal_op
);

  ctrl_t w_ctrl;
  logic  w_illegal;
  ctrl_t w_ctrl_out;
  logic  w_illegal_out;

  main_decoder_comb u_comb (
    .op      (op),
    .ctrl    (w_ctrl),
    .illegal (w_illegal)
  );

  generate
    if (REG_OUT != 0) begin : g_reg
      ctrl_t ctrl_d, ctrl_q;
      logic  illegal_d, illegal_q;

      always_comb begin
        ctrl_d    = w_ctrl;
        illegal_d = w_illegal;
      end

      // Reset wins over decode so the pipeline restarts from a clean no-op.
      always_ff @(posedge clk) begin
        if (reset) begin
          ctrl_q    <= CTRL_NOP;
          illegal_q <= 1'b0;
        end else begin
          ctrl_q    <= ctrl_d;
          illegal_q <= illegal_d;
        end
      end

      assign w_ctrl_out    = ctrl_q;
      assign w_illegal_out = illegal_q;
    end else begin : g_comb
      logic unused_clk_reset;
      assign unused_clk_reset = &{1'b0, clk, reset};
      assign w_ctrl_out       = w_ctrl;
      assign w_illegal_out    = w_illegal;
    end
  endgenerate

  assign reg_write  = w_ctrl_out.reg_write;
  assign imm_src    = w_ctrl_out.imm_src;
  assign alu_srcA   = w_ctrl_out.alu_src_a;
  assign alu_srcB   = w_ctrl_out.alu_src_b;
  assign mem_write  = w_ctrl_out.mem_write;
  assign result_src = w_ctrl_out.result_src;
  assign branch     = w_ctrl_out.branch;
  assign alu_op     = w_ctrl_out.alu_op;
  assign jump       = w_ctrl_out.jump;
  assign illegal_op = w_illegal_out;

endmodule

`default_nettype wire

// File: tb/tb_main_decoder.sv
// ============================================================================
// Module  : tb_main_decoder
// Brief   : directed self-checking bench for registered and combinational decode
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_main_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;

  logic       r_reg_write, r_alu_srcA, r_alu_srcB, r_mem_write, r_branch, r_jump, r_illegal;
  logic [2:0] r_imm_src;
  logic [1:0] r_result_src, r_alu_op;
  logic       c_reg_write, c_alu_srcA, c_alu_srcB, c_mem_write, c_branch, c_jump, c_illegal;
  logic [2:0] c_imm_src;
  logic [1:0] c_result_src, c_alu_op;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  main_decoder #(.REG_OUT(1)) u_dut_reg (
    .clk(clk), .reset(reset), .op(op),
    .reg_write(r_reg_write), .imm_src(r_imm_src), .alu_srcA(r_alu_srcA),
    .alu_srcB(r_alu_srcB), .mem_write(r_mem_write), .result_src(r_result_src),
    .branch(r_branch), .alu_op(r_alu_op), .jump(r_jump), .illegal_op(r_illegal)
  );

  main_decoder #(.REG_OUT(0)) u_dut_comb (
    .clk(clk), .reset(reset), .op(op),
    .reg_write(c_reg_write), .imm_src(c_imm_src), .alu_srcA(c_alu_srcA),
    .alu_srcB(c_alu_srcB), .mem_write(c_mem_write), .result_src(c_result_src),
    .branch(c_branch), .alu_op(c_alu_op), .jump(c_jump), .illegal_op(c_illegal)
  );

  wire [12:0] r_word = {r_reg_write, r_imm_src, r_alu_srcA, r_alu_srcB, r_mem_write,
                        r_result_src, r_branch, r_alu_op, r_jump};
  wire [12:0] c_word = {c_reg_write, c_imm_src, c_alu_srcA, c_alu_srcB, c_mem_write,
                        c_result_src, c_branch, c_alu_op, c_jump};

  localparam logic [6:0]  c_ops   [7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011,
                                          7'b0010011, 7'b1101111, 7'b0110111};
  localparam logic [12:0] c_words [7] = '{13'h1090, 13'h02C0, 13'h1004, 13'h040A,
                                          13'h1084, 13'h1621, 13'h1980};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: expected {illegal, word} from the hand-written table.
  function automatic logic [13:0] ref_decode(input logic [6:0] o);
    ref_decode = {1'b1, 13'h0000};
    for (int k = 0; k < 7; k++)
      if (o == c_ops[k]) ref_decode = {1'b0, c_words[k]};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    op    = 7'b0110011;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (r_word !== 13'h0000 || r_illegal !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got word=%h ill=%b, need 0000 ill=0", k, r_word, r_illegal);
      end
    end
    checks++;
    if (c_word !== 13'h1004 || c_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_comb_ignored: got word=%h ill=%b, need 1004 ill=0", c_word, c_illegal);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (r_word !== 13'h1004 || r_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got word=%h ill=%b, need 1004 ill=0", r_word, r_illegal);
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 7; k++) begin
      op = c_ops[k];
      #1;
      checks++;
      if (c_word !== c_words[k] || c_illegal !== 1'b0) begin
        errors++;
        $display("FAIL sweep_comb op=%b: got word=%h ill=%b, need %h ill=0", op, c_word, c_illegal, c_words[k]);
      end
      checks++;
      if (r_word === c_words[k] && k != 0 && c_words[k] != c_words[k-1]) begin
        errors++;
        $display("FAIL sweep_latency op=%b: got word=%h before edge, need previous %h", op, r_word, c_words[k-1]);
      end
      tick();
      checks++;
      if (r_word !== c_words[k] || r_illegal !== 1'b0) begin
        errors++;
        $display("FAIL sweep_reg op=%b: got word=%h ill=%b, need %h ill=0", op, r_word, r_illegal, c_words[k]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [6:0] bad [3];
    bad = '{7'b0000000, 7'b1111111, 7'b0010111};
    for (int k = 0; k < 3; k++) begin
      op = bad[k];
      tick();
      checks++;
      if (r_word !== 13'h0000 || r_illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_reg op=%b: got word=%h ill=%b, need 0000 ill=1", op, r_word, r_illegal);
      end
      checks++;
      if (c_word !== 13'h0000 || c_illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_comb op=%b: got word=%h ill=%b, need 0000 ill=1", op, c_word, c_illegal);
      end
    end
  endtask

  task automatic test_back_to_back();
    op = 7'b0100011;
    tick();
    checks++;
    if (r_mem_write !== 1'b1 || r_result_src !== 2'b00) begin
      errors++;
      $display("FAIL b2b_sw: got mem_write=%b result_src=%b, need 1 00", r_mem_write, r_result_src);
    end
    op = 7'b0000011;
    tick();
    checks++;
    if (r_mem_write !== 1'b0 || r_result_src !== 2'b01) begin
      errors++;
      $display("FAIL b2b_lw: got mem_write=%b result_src=%b, need 0 01", r_mem_write, r_result_src);
    end
  endtask

  task automatic test_reset_mid();
    op = 7'b1101111;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (r_jump !== 1'b0 || r_reg_write !== 1'b0 || r_word !== 13'h0000) begin
      errors++;
      $display("FAIL reset_mid: got jump=%b reg_write=%b word=%h, need 0 0 0000", r_jump, r_reg_write, r_word);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (r_word !== 13'h1621 || r_illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: got word=%h ill=%b, need 1621 ill=0", r_word, r_illegal);
    end
  endtask

  task automatic test_exhaustive();
    int         legal_r = 0;
    int         legal_c = 0;
    logic [7:0] idx;
    logic [13:0] exp_v;
    for (int i = 0; i < 128; i++) begin
      idx   = 8'(i);
      op    = idx[6:0];
      exp_v = ref_decode(op);
      tick();
      if (r_illegal === 1'b0) legal_r++;
      if (c_illegal === 1'b0) legal_c++;
      checks++;
      if ({r_illegal, r_word} !== exp_v || {c_illegal, c_word} !== exp_v) begin
        errors++;
        $display("FAIL exhaustive op=%b: got reg=%h comb=%h, need %h", op,
                 {r_illegal, r_word}, {c_illegal, c_word}, exp_v);
      end
    end
    checks++;
    if (legal_r != 7 || legal_c != 7) begin
      errors++;
      $display("FAIL exhaustive_count: got legal reg=%0d comb=%0d, need 7", legal_r, legal_c);
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_exhaustive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/main_decoder.md
Name: main_decoder

Overview:
- Main control decoder of the RV32I core datapath: maps the 7-bit instruction opcode to datapath control signals.
- Signals driven: register-file write, immediate format, ALU operand selects, data-memory write, result mux select, branch, jump, ALU-op class.
- Outputs feed the ALU decoder, the immediate extender and the datapath muxes.
- Decode is a pure opcode lookup; the result is registered on one clock, with synchronous reset to a safe no-op.

Parameters:
- REG_OUT, 1, 1 = outputs registered (latency 1 cycle); 0 = outputs combinational from op (clk/reset ignored).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; clears all outputs
- op  in  7  instruction opcode field, instr[6:0]
- reg_write  out  1  write rd in register file
- imm_src  out  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U
- alu_srcA  out  1  ALU A operand: 0 = rs1, 1 = constant zero
- alu_srcB  out  1  ALU B operand: 0 = rs2, 1 = extended immediate
- mem_write  out  1  data-memory write enable
- result_src  out  2  writeback select: 00 ALU result, 01 memory read data, 10 PC+4, 11 reserved
- branch  out  1  conditional branch instruction
- alu_op  out  2  ALU class: 00 add, 01 subtract/compare, 10 decode by funct3/funct7, 11 reserved
- jump  out  1  unconditional jump
- illegal_op  out  1  opcode not in the supported set

Behaviour:
- Packed control word, MSB to LSB: {reg_write, imm_src[2:0], alu_srcA, alu_srcB, mem_write, result_src[1:0], branch, alu_op[1:0], jump} (13 bits).
- Decode table, op -> word:
  - lw 0000011 -> 0x1090
  - sw 0100011 -> 0x02C0
  - R-type 0110011 -> 0x1004
  - beq/branch 1100011 -> 0x040A
  - I-type ALU 0010011 -> 0x1084
  - jal 1101111 -> 0x1621
  - lui 0110111 -> 0x1980 (A = zero, B = U-immediate, add)
- Any other opcode: word = 0x0000 and illegal_op = 1. No register or memory write, no branch or jump.
- Supported opcodes drive illegal_op = 0.
- Fields with no function for an instruction are driven to 0, never X (e.g. R-type imm_src = 000, sw result_src = 00).
- REG_OUT = 1:
  - Outputs update on the rising clk edge from the op present before that edge; latency is exactly 1 cycle.
  - A new op is accepted every cycle; there is no handshake.
- reset = 1 at an edge: all outputs become 0 (word 0x0000, illegal_op 0), regardless of op.
  - Reset takes priority over decode in the same cycle.
  - After reset deasserts, the first edge loads the decode of the current op.
- REG_OUT = 0: outputs follow op combinationally with zero latency; reset has no effect.
- Only op values 0b0000000..0b1111111 exist; no X-propagation handling beyond default = 0.

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_LUI) and encodings for imm_src, result_src and alu_op, for reuse by the extender, ALU decoder and datapath.
- One sub-module is natural: main_decoder_comb, a pure combinational opcode -> 13-bit word + illegal lookup. The top adds the optional output register.

Test Plan:
- Reset: hold reset = 1 with op = 0110011 for 2 cycles -> all outputs 0, illegal_op 0. Release; next edge -> word 0x1004.
- Sweep the supported opcodes in the order lw, sw, R, beq, I, jal, lui, one per cycle -> the listed words, each one cycle after its op. Also sweep with REG_OUT = 0 -> the same words with zero latency.
- Illegal opcodes 0000000, 1111111, 0010111 -> word 0x0000, illegal_op 1.
- Back-to-back changes: sw then lw on consecutive cycles -> mem_write 1 then 0 with no glitch cycle. result_src 00 then 01.
- Reset mid-stream: assert reset while op = 1101111 -> next edge jump 0, reg_write 0. Deassert -> next edge 0x1621.
- Exhaustive sweep of all 128 opcodes -> exactly 7 decode with illegal_op 0; the other 121 give 0x0000 with illegal_op 1.
